// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - single-level exception controller with sticky pending sources
//
// Purpose: latches exception requests, redirects fetch to VECTOR, records
// the return state (ERR/ELR/ESR) and returns through eret.
// Optional feature macro: EXC_CTRL_MASK_EN (per-source enable mask register).
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous active-low reset
//   exc_src      per-source exception request, bit 0 highest priority
//   eret         exception-return instruction in Execute
//   NextPC_F     next PC (saved to ERR)
//   imem_addr_F  fetch PC (saved to ELR, compared with VECTOR for ack)
//   PCBranch_E   execute-stage branch target
//   sys_sel      system register read select: 0 ERR, 1 ELR, 2 ESR, 3 zero
//   mask_wr      source-enable mask write strobe
//   mask_wdata   source-enable mask write data
//   exc_req      forces fetch PC to VECTOR
//   ExcAck       handler fetch acknowledged
//   PCBranch_F   selected branch / return target
//   sys_rdata    selected system register, zero-extended
//   busy         controller not idle

module exception_ctrl #(
  parameter int          N      = 64,
  parameter int          NSRC   = 4,
  parameter int          EW     = 4,
  parameter logic [63:0] VECTOR = 64'hD8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] exc_src,
  input  logic            eret,
  input  logic [N-1:0]    NextPC_F,
  input  logic [N-1:0]    imem_addr_F,
  input  logic [N-1:0]    PCBranch_E,
  input  logic [1:0]      sys_sel,
  input  logic            mask_wr,
  input  logic [NSRC-1:0] mask_wdata,
  output logic            exc_req,
  output logic            ExcAck,
  output logic [N-1:0]    PCBranch_F,
  output logic [N-1:0]    sys_rdata,
  output logic            busy
);

  localparam logic [N-1:0] VEC = N'(VECTOR);

  typedef enum logic [1:0] {IDLE, PENDING, SERVICE} state_t;

  state_t          state;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] eff;
  logic [NSRC-1:0] enable;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] take_onehot;
  logic [EW-1:0]   take_code;
  logic            take_any;
  logic [N-1:0]    err;
  logic [N-1:0]    elr;
  logic [EW-1:0]   esr;

`ifdef EXC_CTRL_MASK_EN
  logic [NSRC-1:0] mask;

  always_ff @(posedge clk) begin
    if (!reset)
      mask <= '1;
    else if (mask_wr)
      mask <= mask_wdata;
  end

  // Write-through: a source enabled by this cycle's write is eligible on the
  // same edge that stores the new mask.
  assign enable = mask_wr ? mask_wdata : mask;
`else
  // Mask inputs have no effect in this build; all sources are eligible.
  assign enable = {NSRC{1'b1}} | (mask_wdata & {NSRC{mask_wr}});
`endif

  // Requests of the current cycle count as already pending, so a request
  // seen in IDLE is taken on the same edge.
  assign eff      = pending | exc_src;
  assign eligible = eff & enable;

  // Lowest-index eligible source wins; ESR holds index+1 so 0 means "none".
  always_comb begin
    take_any    = 1'b0;
    take_onehot = '0;
    take_code   = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (eligible[i] && !take_any) begin
        take_any       = 1'b1;
        take_onehot[i] = 1'b1;
        take_code      = EW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      pending <= '0;
      err     <= '0;
      elr     <= '0;
      esr     <= '0;
    end else begin
      pending <= eff;
      case (state)
        IDLE: begin
          if (take_any) begin
            state   <= PENDING;
            err     <= NextPC_F;
            elr     <= imem_addr_F;
            esr     <= take_code;
            pending <= eff & ~take_onehot;
          end
        end
        PENDING: begin
          if (ExcAck)
            state <= SERVICE;
        end
        SERVICE: begin
          if (eret)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign exc_req    = (state == PENDING);
  assign ExcAck     = exc_req && (imem_addr_F == VEC);
  assign busy       = (state != IDLE);
  assign PCBranch_F = ((state == SERVICE) && eret) ? err : PCBranch_E;

  always_comb begin
    sys_rdata = '0;
    case (sys_sel)
      2'd0:    sys_rdata = err;
      2'd1:    sys_rdata = elr;
      2'd2:    sys_rdata = N'(esr);
      default: sys_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - directed vector bench for exception_ctrl

module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  exc_src;
  logic        eret;
  logic [63:0] NextPC_F;
  logic [63:0] imem_addr_F;
  logic [63:0] PCBranch_E;
  logic [1:0]  sys_sel;
  logic        mask_wr;
  logic [3:0]  mask_wdata;
  logic        exc_req;
  logic        ExcAck;
  logic [63:0] PCBranch_F;
  logic [63:0] sys_rdata;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  exception_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .exc_src     (exc_src),
    .eret        (eret),
    .NextPC_F    (NextPC_F),
    .imem_addr_F (imem_addr_F),
    .PCBranch_E  (PCBranch_E),
    .sys_sel     (sys_sel),
    .mask_wr     (mask_wr),
    .mask_wdata  (mask_wdata),
    .exc_req     (exc_req),
    .ExcAck      (ExcAck),
    .PCBranch_F  (PCBranch_F),
    .sys_rdata   (sys_rdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  src;
    logic        eret;
    logic [63:0] npc;
    logic [63:0] imem;
    logic [63:0] pcbe;
    logic [1:0]  sel;
    logic        req;
    logic        ack;
    logic        bsy;
    logic [63:0] pcbf;
    logic [63:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic [3:0] src, logic er, logic [63:0] npc,
                               logic [63:0] imem, logic [63:0] pcbe, logic [1:0] sel,
                               logic req, logic ack, logic bsy,
                               logic [63:0] pcbf, logic [63:0] rdata);
    vec_t v;
    v.src = src; v.eret = er; v.npc = npc; v.imem = imem; v.pcbe = pcbe;
    v.sel = sel; v.req = req; v.ack = ack; v.bsy = bsy; v.pcbf = pcbf;
    v.rdata = rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] src, input logic er, input logic [63:0] npc,
                       input logic [63:0] imem, input logic [63:0] pcbe,
                       input logic [1:0] sel);
    exc_src = src; eret = er; NextPC_F = npc; imem_addr_F = imem;
    PCBranch_E = pcbe; sys_sel = sel;
    #1;
  endtask

  initial begin
    reset = 1'b0; exc_src = '0; eret = 1'b0; NextPC_F = '0; imem_addr_F = '0;
    PCBranch_E = 64'h40; sys_sel = 2'd0; mask_wr = 1'b0; mask_wdata = '0;
    tick();
    tick();
    reset = 1'b1;

    //            src    eret npc    imem   pcbe   sel  req ack bsy pcbf   rdata
    vecs.push_back(mkv(4'h0, 0, 64'h0,  64'h0,  64'h40, 2, 0, 0, 0, 64'h40, 64'h0));  // reset state
    vecs.push_back(mkv(4'h0, 1, 64'h0,  64'h0,  64'h40, 0, 0, 0, 0, 64'h40, 64'h0));  // eret in IDLE ignored
    vecs.push_back(mkv(4'h4, 0, 64'h14, 64'h10, 64'h44, 3, 0, 0, 0, 64'h44, 64'h0));  // raise src 2
    vecs.push_back(mkv(4'h0, 0, 64'h0,  64'h18, 64'h48, 0, 1, 0, 1, 64'h48, 64'h14)); // ERR
    vecs.push_back(mkv(4'h0, 0, 64'h0,  64'h1C, 64'h48, 1, 1, 0, 1, 64'h48, 64'h10)); // ELR
    vecs.push_back(mkv(4'h0, 0, 64'h0,  64'hD8, 64'h48, 2, 1, 1, 1, 64'h48, 64'h3));  // ack, ESR=3
    vecs.push_back(mkv(4'h1, 0, 64'h99, 64'hDC, 64'h50, 0, 0, 0, 1, 64'h50, 64'h14)); // SERVICE: accumulate
    vecs.push_back(mkv(4'h0, 1, 64'h0,  64'hE0, 64'h50, 2, 0, 0, 1, 64'h14, 64'h3));  // eret -> ERR
    vecs.push_back(mkv(4'h0, 0, 64'h24, 64'h20, 64'h54, 2, 0, 0, 0, 64'h54, 64'h3));  // IDLE, regs held
    vecs.push_back(mkv(4'h0, 0, 64'h0,  64'h28, 64'h54, 2, 1, 0, 1, 64'h54, 64'h1));  // src 0 taken
    vecs.push_back(mkv(4'h0, 0, 64'h0,  64'h2C, 64'h54, 0, 1, 0, 1, 64'h54, 64'h24)); // ERR of src 0

    foreach (vecs[k]) begin
      drive(vecs[k].src, vecs[k].eret, vecs[k].npc, vecs[k].imem, vecs[k].pcbe, vecs[k].sel);
      chk($sformatf("v%0d_exc_req", k), 64'(exc_req), 64'(vecs[k].req));
      chk($sformatf("v%0d_ExcAck", k), 64'(ExcAck), 64'(vecs[k].ack));
      chk($sformatf("v%0d_busy", k), 64'(busy), 64'(vecs[k].bsy));
      chk($sformatf("v%0d_PCBranch_F", k), PCBranch_F, vecs[k].pcbf);
      chk($sformatf("v%0d_sys_rdata", k), sys_rdata, vecs[k].rdata);
      tick();
    end

    // Reset in SERVICE; requests during reset must not be latched.
    drive(4'h0, 0, 64'h0, 64'hD8, 64'h58, 2);
    chk("rst_pre_ack", 64'(ExcAck), 64'h1);
    tick();
    chk("rst_in_service", 64'(busy), 64'h1);
    reset = 1'b0;
    drive(4'hF, 0, 64'h0, 64'h0, 64'h58, 2);
    tick();
    drive(4'hF, 0, 64'h0, 64'h0, 64'h58, 2);
    tick();
    reset = 1'b1;
    drive(4'h0, 0, 64'h0, 64'h0, 64'h58, 2);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_exc_req", 64'(exc_req), 64'h0);
    chk("rst_esr", sys_rdata, 64'h0);
    sys_sel = 2'd0; #1;
    chk("rst_err", sys_rdata, 64'h0);
    sys_sel = 2'd1; #1;
    chk("rst_elr", sys_rdata, 64'h0);
    chk("rst_pcbf", PCBranch_F, 64'h58);
    tick();
    drive(4'h0, 0, 64'h0, 64'h0, 64'h58, 2);
    chk("rst_pending_clear", 64'(exc_req), 64'h0);
    tick();

    // Two sources in one cycle: lower index first, the other after eret.
    drive(4'h6, 0, 64'h34, 64'h30, 64'h60, 2);
    tick();
    drive(4'h0, 0, 64'h0, 64'h30, 64'h60, 2);
    chk("dual_req", 64'(exc_req), 64'h1);
    chk("dual_esr1", sys_rdata, 64'h2);
    tick();
    drive(4'h0, 0, 64'h0, 64'hD8, 64'h60, 2);
    chk("dual_ack1", 64'(ExcAck), 64'h1);
    tick();
    drive(4'h0, 1, 64'h0, 64'hDC, 64'h60, 0);
    chk("dual_eret_pcbf", PCBranch_F, 64'h34);
    tick();
    drive(4'h0, 0, 64'h74, 64'h70, 64'h60, 2);
    chk("dual_idle_gap", 64'(busy), 64'h0);
    tick();
    drive(4'h0, 0, 64'h0, 64'h78, 64'h60, 2);
    chk("dual_req2", 64'(exc_req), 64'h1);
    chk("dual_esr2", sys_rdata, 64'h3);
    sys_sel = 2'd1; #1;
    chk("dual_elr2", sys_rdata, 64'h70);
    tick();
    drive(4'h0, 0, 64'h0, 64'hD8, 64'h60, 2);
    tick();
    // Request raised in the eret cycle is taken after one IDLE cycle.
    drive(4'h8, 1, 64'h0, 64'hDC, 64'h60, 0);
    chk("eret_src_pcbf", PCBranch_F, 64'h74);
    tick();
    drive(4'h0, 0, 64'h84, 64'h80, 64'h60, 2);
    chk("eret_src_idle", 64'(busy), 64'h0);
    tick();
    drive(4'h0, 0, 64'h0, 64'h88, 64'h60, 2);
    chk("eret_src_req", 64'(exc_req), 64'h1);
    chk("eret_src_esr", sys_rdata, 64'h4);
    tick();
    drive(4'h0, 0, 64'h0, 64'hD8, 64'h60, 2);
    tick();
    drive(4'h0, 1, 64'h0, 64'hDC, 64'h60, 2);
    tick();

`ifdef EXC_CTRL_MASK_EN
    mask_wr = 1'b1; mask_wdata = 4'hE;
    drive(4'h0, 0, 64'h0, 64'h90, 64'h60, 2);
    tick();
    mask_wr = 1'b0;
    drive(4'h1, 0, 64'h0, 64'h94, 64'h60, 2);
    tick();
    drive(4'h0, 0, 64'h0, 64'h98, 64'h60, 2);
    chk("mask_blocked1", 64'(exc_req), 64'h0);
    tick();
    drive(4'h0, 0, 64'hA4, 64'hA0, 64'h60, 2);
    chk("mask_blocked2", 64'(exc_req), 64'h0);
    mask_wr = 1'b1; mask_wdata = 4'hF;
    #1;
    tick();
    mask_wr = 1'b0;
    drive(4'h0, 0, 64'h0, 64'hA8, 64'h60, 2);
    chk("mask_release_req", 64'(exc_req), 64'h1);
    chk("mask_release_esr", sys_rdata, 64'h1);
`else
    mask_wr = 1'b1; mask_wdata = 4'h0;
    drive(4'h1, 0, 64'hA4, 64'hA0, 64'h60, 2);
    tick();
    mask_wr = 1'b0;
    drive(4'h0, 0, 64'h0, 64'hA8, 64'h60, 2);
    chk("nomask_req", 64'(exc_req), 64'h1);
    chk("nomask_esr", sys_rdata, 64'h1);
`endif
    sys_sel = 2'd0; #1;
    chk("final_err", sys_rdata, 64'hA4);
    sys_sel = 2'd3; #1;
    chk("sel3_zero", sys_rdata, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 SHALL have parameter N, default 64, meaning address/data width.
REQ-002 SHALL have parameter NSRC, default 4, meaning number of exception sources (1..15).
REQ-003 SHALL have parameter EW, default 4, meaning ESR cause-code width; NSRC < 2**EW.
REQ-004 SHALL have parameter VECTOR, default 64'hD8, meaning exception handler address (low N bits used).
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset  in  1  synchronous active-low reset.
REQ-007 SHALL have port exc_src  in  NSRC  exception request per source, bit 0 highest priority.
REQ-008 SHALL have port eret  in  1  exception-return instruction in Execute.
REQ-009 SHALL have ports NextPC_F, imem_addr_F, PCBranch_E  in  N each  next PC, fetch PC, execute branch target.
REQ-010 SHALL have port sys_sel  in  2  system-register read select (0 ERR, 1 ELR, 2 ESR, 3 zero).
REQ-011 SHALL have ports mask_wr in 1 and mask_wdata in NSRC  source-enable mask write.
REQ-012 SHALL have port exc_req  out  1  forces fetch PC to VECTOR.
REQ-013 SHALL have port ExcAck  out  1  handler fetch acknowledged.
REQ-014 SHALL have port PCBranch_F  out  N  selected branch/return target.
REQ-015 SHALL have port sys_rdata  out  N  selected system register, zero-extended.
REQ-016 SHALL have port busy  out  1  state is not IDLE.

Function
REQ-017 SHALL hold a sticky pending vector; bit i sets on any cycle exc_src[i]=1, clears only when that source is taken or on reset.
REQ-018 SHALL implement states IDLE, PENDING, SERVICE.
REQ-019 IDLE: if any enabled pending bit at clock edge, SHALL go to PENDING and in that same edge load ERR<=NextPC_F, ELR<=imem_addr_F, ESR<=index+1 of lowest-index enabled pending bit, and clear that bit.
REQ-020 PENDING: exc_req SHALL be 1; ExcAck SHALL be 1 combinationally when imem_addr_F==VECTOR; next state SERVICE on ExcAck.
REQ-021 SERVICE: new requests SHALL only accumulate in pending (no nesting); ERR/ELR/ESR SHALL hold.
REQ-022 SERVICE with eret=1: PCBranch_F SHALL equal ERR combinationally; next state IDLE.
REQ-023 PCBranch_F SHALL equal PCBranch_E whenever not (SERVICE and eret); eret outside SERVICE SHALL be ignored.
REQ-024 exc_src asserted in the eret cycle SHALL be latched and taken from IDLE on the following edge (one IDLE cycle).
REQ-025 sys_rdata SHALL be combinational from sys_sel, ESR zero-extended to N.
REQ-026 ERR/ELR/ESR SHALL change only on the IDLE->PENDING edge.

Reset
REQ-027 reset=0 at a rising edge SHALL force IDLE, clear pending, ERR/ELR/ESR to 0, mask to all-ones, regardless of state (mid-exception included).
REQ-028 After reset: exc_req=0, ExcAck=0, busy=0, PCBranch_F=PCBranch_E, sys_rdata=0.
REQ-029 Requests arriving while reset=0 SHALL not be latched.

Configuration
REQ-030 With macro EXC_CTRL_MASK_EN defined, mask register SHALL load mask_wdata on mask_wr=1; only pending bits with mask=1 are eligible; masked bits stay pending.
REQ-031 Without EXC_CTRL_MASK_EN, mask_wr/mask_wdata SHALL be ignored and all sources eligible.

Verification
REQ-032 exc_src=4'b0100 in IDLE, NextPC_F=0x14, imem_addr_F=0x10 -> next cycle exc_req=1, ERR=0x14, ELR=0x10, ESR=3.
REQ-033 exc_src=4'b0110 one cycle -> ESR=2 first; after eret, source 2 taken with ESR=3.
REQ-034 PENDING, imem_addr_F=0xD8 -> ExcAck=1 that cycle, state SERVICE; eret=1 -> PCBranch_F=ERR, next IDLE.
REQ-035 eret=1 in IDLE with PCBranch_E=0x40 -> PCBranch_F=0x40, state unchanged.
REQ-036 reset=0 during SERVICE -> next cycle busy=0, ESR=0, pending=0.
REQ-037 EXC_CTRL_MASK_EN: mask=4'b1110, exc_src=4'b0001 -> no exc_req; write mask=4'b1111 -> exc_req next cycle, ESR=1.
